// File: rtl/fft_bin_serializer_pkg.sv
// Shared constants and types for the FFT bin serializer.
// Bin words are {re[31:16], im[15:0]}, both signed, and are carried through untouched.
package fft_bin_serializer_pkg;

    localparam int unsigned NUM_BINS = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DEF_BIN_W = 32;

    typedef enum logic {
        StIdle,
        StSend
    } out_state_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One FFT frame worth of storage: every bin is written in parallel, one bin is read
// combinationally.
module fft_frame_bank
    import fft_bin_serializer_pkg::*;
#(
    parameter int unsigned BIN_W = DEF_BIN_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [BIN_W-1:0] d0,
    input  logic [BIN_W-1:0] d1,
    input  logic [BIN_W-1:0] d2,
    input  logic [BIN_W-1:0] d3,
    input  logic [BIN_W-1:0] d4,
    input  logic [BIN_W-1:0] d5,
    input  logic [BIN_W-1:0] d6,
    input  logic [BIN_W-1:0] d7,
    input  logic [BIN_W-1:0] d8,
    input  logic [BIN_W-1:0] d9,
    input  logic [BIN_W-1:0] d10,
    input  logic [BIN_W-1:0] d11,
    input  logic [BIN_W-1:0] d12,
    input  logic [BIN_W-1:0] d13,
    input  logic [BIN_W-1:0] d14,
    input  logic [BIN_W-1:0] d15,
    input  logic [IDX_W-1:0] ridx,
    output logic [BIN_W-1:0] rdata
);

    logic [BIN_W-1:0] mem_q [NUM_BINS];
    logic [BIN_W-1:0] mem_d [NUM_BINS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d = '{d0, d1, d2, d3, d4, d5, d6, d7,
                      d8, d9, d10, d11, d12, d13, d14, d15};
        end
    end

    // Data storage needs no reset: the full flags in the parent gate every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/fft_bin_serializer.sv
// Captures 16-bin FFT frames into two ping-pong banks and replays them one bin per beat
// on a valid/ready stream; frames arriving with both banks occupied are dropped and counted.
module fft_bin_serializer
    import fft_bin_serializer_pkg::*;
#(
    parameter int unsigned BIN_W  = DEF_BIN_W,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [BIN_W-1:0]  fft_d0,
    input  logic [BIN_W-1:0]  fft_d1,
    input  logic [BIN_W-1:0]  fft_d2,
    input  logic [BIN_W-1:0]  fft_d3,
    input  logic [BIN_W-1:0]  fft_d4,
    input  logic [BIN_W-1:0]  fft_d5,
    input  logic [BIN_W-1:0]  fft_d6,
    input  logic [BIN_W-1:0]  fft_d7,
    input  logic [BIN_W-1:0]  fft_d8,
    input  logic [BIN_W-1:0]  fft_d9,
    input  logic [BIN_W-1:0]  fft_d10,
    input  logic [BIN_W-1:0]  fft_d11,
    input  logic [BIN_W-1:0]  fft_d12,
    input  logic [BIN_W-1:0]  fft_d13,
    input  logic [BIN_W-1:0]  fft_d14,
    input  logic [BIN_W-1:0]  fft_d15,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIN_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              frame_drop,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_BINS - 1);

    out_state_e        state_q, state_d;
    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              frame_drop_q, frame_drop_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              hs, last_hs, wr_free, capture;
    logic [BIN_W-1:0]  rdata0, rdata1;

    always_comb begin
        hs      = (state_q == StSend) && out_ready;
        last_hs = hs && (idx_q == LastIdx);
        // A bank whose final beat leaves this cycle can take the incoming frame.
        wr_free = !bank_full_q[wr_bank_q] || (last_hs && (rd_bank_q == wr_bank_q));
        capture = fft_valid && wr_free;
    end

    fft_frame_bank #(.BIN_W(BIN_W)) u_bank0 (
        .clk   (clk),
        .we    (capture && !wr_bank_q),
        .d0    (fft_d0),  .d1  (fft_d1),  .d2  (fft_d2),  .d3  (fft_d3),
        .d4    (fft_d4),  .d5  (fft_d5),  .d6  (fft_d6),  .d7  (fft_d7),
        .d8    (fft_d8),  .d9  (fft_d9),  .d10 (fft_d10), .d11 (fft_d11),
        .d12   (fft_d12), .d13 (fft_d13), .d14 (fft_d14), .d15 (fft_d15),
        .ridx  (idx_q),
        .rdata (rdata0)
    );

    fft_frame_bank #(.BIN_W(BIN_W)) u_bank1 (
        .clk   (clk),
        .we    (capture && wr_bank_q),
        .d0    (fft_d0),  .d1  (fft_d1),  .d2  (fft_d2),  .d3  (fft_d3),
        .d4    (fft_d4),  .d5  (fft_d5),  .d6  (fft_d6),  .d7  (fft_d7),
        .d8    (fft_d8),  .d9  (fft_d9),  .d10 (fft_d10), .d11 (fft_d11),
        .d12   (fft_d12), .d13 (fft_d13), .d14 (fft_d14), .d15 (fft_d15),
        .ridx  (idx_q),
        .rdata (rdata1)
    );

    always_comb begin
        bank_full_d  = bank_full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        state_d      = state_q;
        idx_d        = idx_q;
        frame_drop_d = fft_valid && !wr_free;
        drop_cnt_d   = drop_cnt_q;

        if (frame_drop_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end

        if (last_hs) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = !rd_bank_q;
        end
        // Set after clear so a coincident capture into the released bank wins.
        if (capture) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = !wr_bank_q;
        end

        unique case (state_q)
            StIdle: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (last_hs) begin
                    idx_d = '0;
                    if (!bank_full_q[!rd_bank_q]) begin
                        state_d = StIdle;
                    end
                end else if (hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bank_full_q  <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            idx_q        <= '0;
            frame_drop_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            bank_full_q  <= bank_full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            idx_q        <= idx_d;
            frame_drop_q <= frame_drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = (state_q == StSend);
    assign out_idx    = idx_q;
    assign out_last   = out_valid && (idx_q == LastIdx);
    assign out_data   = rd_bank_q ? rdata1 : rdata0;
    assign frame_drop = frame_drop_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = |bank_full_q;

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Bench for fft_bin_serializer: a frame-queue model checked every cycle, plus directed
// scenarios with literal expectations on beat timing, ordering and drop counting.
module tb_fft_bin_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] d [16];
    logic        out_valid, out_last, frame_drop, busy;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic [7:0]  drop_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    fft_bin_serializer #(.BIN_W(32), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fft_valid  (fft_valid),
        .fft_d0     (d[0]),  .fft_d1  (d[1]),  .fft_d2  (d[2]),  .fft_d3  (d[3]),
        .fft_d4     (d[4]),  .fft_d5  (d[5]),  .fft_d6  (d[6]),  .fft_d7  (d[7]),
        .fft_d8     (d[8]),  .fft_d9  (d[9]),  .fft_d10 (d[10]), .fft_d11 (d[11]),
        .fft_d12    (d[12]), .fft_d13 (d[13]), .fft_d14 (d[14]), .fft_d15 (d[15]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_drop (frame_drop),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fdat(input int tag, input int k);
        logic [15:0] hi, lo;
        hi = 16'(tag * 16 + k);
        lo = 16'(-k);
        return {hi, lo};
    endfunction

    // Model: queue of stored frames; head is the one being sent.
    logic [511:0] mq [$];
    logic [511:0] m_frame, m_cur;
    logic         mv = 1'b0;
    int           midx = 0;
    logic         mdrop = 1'b0;
    int           mcnt = 0;
    bit           minit = 1'b0;
    bit           m_hs, m_last, m_free;
    int           m_pre;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            mv = 1'b0; midx = 0; mdrop = 1'b0; mcnt = 0; minit = 1'b1;
        end else begin
            m_hs   = mv && out_ready;
            m_last = m_hs && (midx == 15);
            m_pre  = mq.size();
            m_free = (m_pre < 2) || m_last;
            if (m_last) void'(mq.pop_front());
            if (fft_valid && m_free) begin
                for (int k = 0; k < 16; k++) m_frame[k*32 +: 32] = d[k];
                mq.push_back(m_frame);
            end
            mdrop = fft_valid && !m_free;
            if (mdrop && mcnt < 255) mcnt++;
            if (mv) begin
                if (m_last) begin
                    mv   = (m_pre == 2);
                    midx = 0;
                end else if (m_hs) begin
                    midx++;
                end
            end else begin
                mv   = (m_pre >= 1);
                midx = 0;
            end
        end
    end

    // Beat log of accepted handshakes, stamped with the cycle the beat became visible.
    int          lcyc [$];
    int          lidx [$];
    logic [31:0] ldat [$];
    int          drops_seen = 0;

    always @(negedge clk) begin
        if (minit) begin
            chk("valid", out_valid, mv);
            chk("busy", busy, mq.size() != 0);
            chk("frame_drop", frame_drop, mdrop);
            chk("drop_cnt", drop_cnt, mcnt);
            if (mv) begin
                if (mq.size() == 0) begin
                    chk("model_head", 0, 1);
                end else begin
                    m_cur = mq[0];
                    chk("idx", out_idx, midx);
                    chk("last", out_last, midx == 15);
                    chk("data", out_data, m_cur[midx*32 +: 32]);
                end
            end
            if (out_valid && out_ready && !rst) begin
                lcyc.push_back(cyc);
                lidx.push_back(int'(out_idx));
                ldat.push_back(out_data);
            end
            if (frame_drop) drops_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int tag);
        for (int k = 0; k < 16; k++) d[k] = fdat(tag, k);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((busy || out_valid) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 1, 0);
    endtask

    task automatic clear_log();
        lcyc.delete();
        lidx.delete();
        ldat.delete();
    endtask

    task automatic check_frame(input string name, input int base, input int tag);
        int bad = 0;
        if (ldat.size() < base + 16) begin
            bad = 16;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ldat[base+i] !== fdat(tag, i) || lidx[base+i] != i) bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    int  cap;
    bit  found;

    initial begin
        for (int k = 0; k < 16; k++) d[k] = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_drop", frame_drop, 0);
        chk("rst_cnt", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single frame, always ready.
        out_ready = 1'b1;
        repeat (5) tick();
        clear_log();
        send(0);
        cap = cyc;
        drain(200);
        chk("t1_beats", ldat.size(), 16);
        if (ldat.size() == 16) begin
            chk("t1_first_cyc", lcyc[0], cap + 1);
            chk("t1_last_cyc", lcyc[15], cap + 16);
            chk("t1_bin5", ldat[5], 32'h0005_fffb);
            chk("t1_bin15", ldat[15], 32'h000f_fff1);
        end
        check_frame("t1_frame", 0, 0);
        chk("t1_busy_after", busy, 0);

        // Backpressure: ready toggles every cycle.
        clear_log();
        send(1);
        for (int i = 0; i < 100 && (busy || out_valid); i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        chk("t2_beats", ldat.size(), 16);
        check_frame("t2_frame", 0, 1);

        // Back-to-back frames two cycles apart.
        clear_log();
        send(2);
        tick();
        send(3);
        drain(200);
        chk("t3_beats", ldat.size(), 32);
        check_frame("t3_a", 0, 2);
        check_frame("t3_b", 16, 3);
        if (ldat.size() == 32) chk("t3_no_bubble", lcyc[16], lcyc[15] + 1);
        chk("t3_cnt", drop_cnt, 0);

        // Overflow: third frame dropped while both banks wait.
        clear_log();
        drops_seen = 0;
        out_ready  = 1'b0;
        send(4);
        send(5);
        send(6);
        tick();
        tick();
        chk("t4_cnt", drop_cnt, 1);
        chk("t4_pulses", drops_seen, 1);
        chk("t4_busy", busy, 1);
        out_ready = 1'b1;
        drain(200);
        chk("t4_beats", ldat.size(), 32);
        check_frame("t4_a", 0, 4);
        check_frame("t4_b", 16, 5);

        // Coincident release: capture lands on the final handshake of the first bank.
        clear_log();
        out_ready = 1'b0;
        send(7);
        send(8);
        tick();
        tick();
        out_ready = 1'b1;
        repeat (15) tick();
        chk("t5_align_idx", out_idx, 15);
        send(9);
        drain(200);
        chk("t5_cnt", drop_cnt, 1);
        chk("t5_pulses", drops_seen, 1);
        chk("t5_beats", ldat.size(), 48);
        check_frame("t5_a", 0, 7);
        check_frame("t5_b", 16, 8);
        check_frame("t5_c", 32, 9);

        // Reset in the middle of a frame.
        send(10);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_idx == 4'd7) found = 1'b1;
            else tick();
        end
        chk("t6_reached_idx7", found, 1);
        rst = 1'b1;
        tick();
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", drop_cnt, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_idle", out_valid, 0);
        clear_log();
        send(11);
        drain(200);
        chk("t6_beats", ldat.size(), 16);
        check_frame("t6_frame", 0, 11);

        // Saturating drop counter.
        clear_log();
        out_ready = 1'b0;
        send(12);
        send(13);
        for (int i = 0; i < 300; i++) send(20);
        chk("t7_pulse_last", frame_drop, 1);
        tick();
        chk("t7_cnt", drop_cnt, 255);
        chk("t7_pulse_gone", frame_drop, 0);
        out_ready = 1'b1;
        drain(200);
        chk("t7_beats", ldat.size(), 32);
        check_frame("t7_a", 0, 12);
        check_frame("t7_b", 16, 13);
        chk("t7_cnt_hold", drop_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
